video_stream_tx: RTL and testbench

Frame-timing transmitter that produces the pixel-stream protocol consumed by the image-preprocessing ASIC: VSYNC, HSYNC, EN and 8-bit byte-serial data. RGB pixels are sent as three consecutive bytes, R, G, B. It pulls bytes from an upstream source over a valid/ready handshake and emits complete frames with programmable active size and blanking. It is the stimulus and source end of the same interface that the ASIC receives on InVSYNC, InHSYNC, InEN and InData.

---
 rtl/video_stream_tx.sv | 131 +++++++++++++
 tb/tb_video_stream_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_tx.sv
// Frame-timing transmitter: emits VSYNC/HSYNC/EN plus byte-serial pixel data
// pulled from an upstream valid/ready source. All Tx outputs are registered.
module video_stream_tx #(
    parameter int unsigned H_ACT    = 24,
    parameter int unsigned H_BLANK  = 8,
    parameter int unsigned V_ACT    = 4,
    parameter int unsigned VS_LINES = 1,
    parameter int unsigned V_BP     = 1,
    parameter int unsigned V_FP     = 1
) (
    input  logic       clk_sys,
    input  logic       reset_sys,
    input  logic       tx_en,
    input  logic       src_valid,
    input  logic [7:0] src_data,
    output logic       src_ready,
    output logic       TxVSYNC,
    output logic       TxHSYNC,
    output logic       TxEN,
    output logic [7:0] TxData,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam int unsigned HTotal = H_ACT + H_BLANK;
    localparam int unsigned ColW   = $clog2(HTotal);
    localparam int unsigned LnMaxA = (VS_LINES > V_BP) ? VS_LINES : V_BP;
    localparam int unsigned LnMaxB = (V_ACT > V_FP) ? V_ACT : V_FP;
    localparam int unsigned LnMax  = (LnMaxA > LnMaxB) ? LnMaxA : LnMaxB;
    localparam int unsigned LnW    = (LnMax > 1) ? $clog2(LnMax) : 1;

    localparam logic [ColW-1:0] ColLast = ColW'(HTotal - 1);
    localparam logic [ColW-1:0] ColAct  = ColW'(H_ACT);

    typedef enum logic [2:0] {StIdle, StVsync, StVbp, StActive, StVfp} state_e;

    state_e          state_q, state_d;
    logic [ColW-1:0] col_q, col_d;
    logic [LnW-1:0]  ln_q, ln_d, ln_last;
    logic            col_end, state_end, win, xfer, frame_end;

    logic            vsync_q, hsync_q, en_q, frame_done_q, underrun_q;
    logic [7:0]      data_q;

    // State register and position counters
    always_ff @(posedge clk_sys or negedge reset_sys) begin
        if (!reset_sys) begin
            state_q <= StIdle;
            col_q   <= '0;
            ln_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            ln_q    <= ln_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        ln_last = '0;
        case (state_q)
            StVsync:  ln_last = LnW'(VS_LINES - 1);
            StVbp:    ln_last = LnW'(V_BP - 1);
            StActive: ln_last = LnW'(V_ACT - 1);
            StVfp:    ln_last = LnW'(V_FP - 1);
            default:  ln_last = '0;
        endcase

        col_end   = (col_q == ColLast);
        state_end = col_end && (ln_q == ln_last);

        state_d = state_q;
        case (state_q)
            StIdle:   if (tx_en) state_d = StVsync;
            StVsync:  if (state_end) state_d = StVbp;
            StVbp:    if (state_end) state_d = StActive;
            StActive: if (state_end) state_d = StVfp;
            StVfp:    if (state_end) state_d = tx_en ? StVsync : StIdle;
            default:  state_d = StIdle;
        endcase

        col_d = col_q;
        ln_d  = ln_q;
        if (state_q == StIdle) begin
            col_d = '0;
            ln_d  = '0;
        end else if (col_end) begin
            col_d = '0;
            ln_d  = state_end ? '0 : ln_q + LnW'(1);
        end else begin
            col_d = col_q + ColW'(1);
        end
    end

    // Combinational outputs and handshake decode
    always_comb begin
        win       = (state_q == StActive) && (col_q < ColAct);
        xfer      = win && src_valid;
        frame_end = (state_q == StVfp) && state_end;
        src_ready = win;
        busy      = (state_q != StIdle);
    end

    // One-cycle output register keeps all Tx signals mutually aligned
    always_ff @(posedge clk_sys or negedge reset_sys) begin
        if (!reset_sys) begin
            vsync_q      <= 1'b0;
            hsync_q      <= 1'b0;
            en_q         <= 1'b0;
            data_q       <= 8'h00;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            vsync_q      <= (state_q == StVsync);
            hsync_q      <= win;
            en_q         <= xfer;
            data_q       <= xfer ? src_data : 8'h00;
            frame_done_q <= frame_end;
            underrun_q   <= underrun_q | (win & ~src_valid);
        end
    end

    assign TxVSYNC    = vsync_q;
    assign TxHSYNC    = hsync_q;
    assign TxEN       = en_q;
    assign TxData     = data_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_video_stream_tx.sv
// Self-checking bench for video_stream_tx: a frame-position model (plain
// arithmetic on the cycle index within a frame) predicts every output each cycle.
module tb_video_stream_tx;

    localparam int H_ACT = 24, H_BLANK = 8, V_ACT = 4, VS_LINES = 1, V_BP = 1, V_FP = 1;
    localparam int HT   = H_ACT + H_BLANK;
    localparam int F    = (VS_LINES + V_BP + V_ACT + V_FP) * HT;
    localparam int ACT0 = (VS_LINES + V_BP) * HT;
    localparam int ACT1 = (VS_LINES + V_BP + V_ACT) * HT;

    logic       clk_sys, reset_sys, tx_en, src_valid;
    logic [7:0] src_data;
    logic       src_ready, TxVSYNC, TxHSYNC, TxEN, busy, frame_done, underrun;
    logic [7:0] TxData;

    video_stream_tx #(
        .H_ACT(H_ACT), .H_BLANK(H_BLANK), .V_ACT(V_ACT),
        .VS_LINES(VS_LINES), .V_BP(V_BP), .V_FP(V_FP)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_sys (reset_sys),
        .tx_en     (tx_en),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .TxVSYNC   (TxVSYNC),
        .TxHSYNC   (TxHSYNC),
        .TxEN      (TxEN),
        .TxData    (TxData),
        .busy      (busy),
        .frame_done(frame_done),
        .underrun  (underrun)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int n_pass = 0, n_fail = 0, n_total = 0;

    // Model: m_pos = -1 when idle, else cycle index within the current frame.
    int         m_pos = -1, m_starts = 0;
    bit         e_vs, e_hs, e_en, e_fd, e_ur;
    logic [7:0] e_data;
    int         mode = 0, cyc = 0;
    logic [7:0] nb = 8'd0;

    int         c_en, c_vs, c_hs, c_fd, c_busy, t0;
    logic [7:0] first_data, last_data;
    bit         prev_vs;
    int         rises[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit f_win(int p);
        return p >= ACT0 && p < ACT1 && (p % HT) < H_ACT;
    endfunction

    function automatic bit f_vs(int p);
        return p >= 0 && p < VS_LINES * HT;
    endfunction

    task automatic m_reset();
        m_pos = -1; e_vs = 0; e_hs = 0; e_en = 0; e_fd = 0; e_ur = 0; e_data = 8'h00;
    endtask

    task automatic clr();
        c_en = 0; c_vs = 0; c_hs = 0; c_fd = 0; c_busy = 0;
        first_data = 8'hxx; last_data = 8'hxx; rises.delete();
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_src_ready"}, src_ready, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_TxVSYNC"}, TxVSYNC, 0);
        chk({pfx, "_TxHSYNC"}, TxHSYNC, 0);
        chk({pfx, "_TxEN"}, TxEN, 0);
        chk({pfx, "_TxData"}, TxData, 0);
        chk({pfx, "_frame_done"}, frame_done, 0);
        chk({pfx, "_underrun"}, underrun, 0);
    endtask

    // One clock: drive inputs, compare outputs against the model, advance the model.
    task automatic tick();
        bit w;
        w = f_win(m_pos);
        case (mode)
            0: begin src_valid = 1'b1; src_data = nb; end
            1: begin src_valid = 1'($urandom_range(0, 1)); src_data = 8'($urandom); end
            default: begin
                src_valid = !(m_pos >= ACT0 + HT + 10 && m_pos <= ACT0 + HT + 12);
                src_data  = nb;
            end
        endcase
        #1;
        chk("src_ready", src_ready, w);
        chk("busy", busy, m_pos >= 0);
        chk("TxVSYNC", TxVSYNC, e_vs);
        chk("TxHSYNC", TxHSYNC, e_hs);
        chk("TxEN", TxEN, e_en);
        chk("TxData", TxData, e_data);
        chk("frame_done", frame_done, e_fd);
        chk("underrun", underrun, e_ur);

        if (TxEN === 1'b1) begin
            c_en++;
            if (c_en == 1) first_data = TxData;
            last_data = TxData;
        end
        if (TxVSYNC === 1'b1) begin
            c_vs++;
            if (!prev_vs) rises.push_back(cyc);
        end
        prev_vs = (TxVSYNC === 1'b1);
        if (TxHSYNC === 1'b1) c_hs++;
        if (frame_done === 1'b1) c_fd++;
        if (busy === 1'b1) c_busy++;

        e_vs   = f_vs(m_pos);
        e_hs   = w;
        e_en   = w && src_valid;
        e_data = e_en ? src_data : 8'h00;
        e_fd   = (m_pos == F - 1);
        if (w && !src_valid) e_ur = 1;
        if (w && src_valid) nb = nb + 8'd1;
        if (m_pos < 0 || m_pos == F - 1) begin
            m_pos = tx_en ? 0 : -1;
            if (tx_en) m_starts++;
        end else begin
            m_pos++;
        end
        @(negedge clk_sys);
        cyc++;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_sys = 1'b0; tx_en = 1'b0; src_valid = 1'b0; src_data = 8'h00;
        m_reset(); prev_vs = 0;
        repeat (3) @(negedge clk_sys);
        #1;
        chk_zero("reset");
        reset_sys = 1'b1;
        @(negedge clk_sys);

        // Nominal single frame, tx_en pulsed one cycle
        clr(); mode = 0; nb = 8'd0;
        t0 = cyc;
        tx_en = 1'b1; tick(); tx_en = 1'b0;
        repeat (F + 20) tick();
        chk("nom_en_cycles", c_en, 96);
        chk("nom_hs_cycles", c_hs, 96);
        chk("nom_vs_cycles", c_vs, VS_LINES * HT);
        chk("nom_frame_done", c_fd, 1);
        chk("nom_first_data", first_data, 8'd0);
        chk("nom_last_data", last_data, 8'd95);
        chk("nom_vs_rise_lat", rises.size() > 0 ? rises[0] - t0 : -1, 2);
        chk("nom_idle_busy", busy, 0);

        // Three back-to-back frames
        clr(); m_starts = 0;
        for (int i = 0; i < 3 * F + 40; i++) begin
            tx_en = (m_starts < 3);
            tick();
        end
        chk("cont_vs_rises", rises.size(), 3);
        chk("cont_frame_done", c_fd, 3);
        chk("cont_busy_cycles", c_busy, 3 * F);
        if (rises.size() == 3) begin
            chk("cont_gap_1", rises[1] - rises[0], F);
            chk("cont_gap_2", rises[2] - rises[1], F);
        end

        // tx_en dropped during the active region
        clr();
        tx_en = 1'b1;
        repeat (ACT0 + 5) tick();
        tx_en = 1'b0;
        repeat (F) tick();
        chk("drop_busy_cycles", c_busy, F);
        chk("drop_frame_done", c_fd, 1);
        clr();
        repeat (50) tick();
        chk("drop_no_vsync", c_vs, 0);
        chk("drop_busy_low", busy, 0);

        // Three missing bytes mid second active line
        clr(); mode = 2;
        chk("ur_before", underrun, 0);
        tx_en = 1'b1; tick(); tx_en = 1'b0;
        repeat (F + 20) tick();
        chk("ur_hs_cycles", c_hs, 96);
        chk("ur_en_cycles", c_en, 93);
        chk("ur_sticky", underrun, 1);

        // Random src_valid handshake
        clr(); mode = 1;
        tx_en = 1'b1; tick(); tx_en = 1'b0;
        repeat (F + 20) tick();
        chk("rand_frame_done", c_fd, 1);
        chk("rand_hs_cycles", c_hs, 96);

        // Asynchronous reset while TxHSYNC is high
        mode = 0;
        tx_en = 1'b1; tick(); tx_en = 1'b0;
        repeat (ACT0 + 6) tick();
        chk("pre_rst_hsync", TxHSYNC, 1);
        reset_sys = 1'b0;
        #1;
        chk_zero("midrst");
        m_reset();
        @(negedge clk_sys);
        cyc++;
        reset_sys = 1'b1;
        clr(); nb = 8'd0;
        t0 = cyc;
        tx_en = 1'b1; tick(); tx_en = 1'b0;
        repeat (F + 20) tick();
        chk("post_rst_vs_lat", rises.size() > 0 ? rises[0] - t0 : -1, 2);
        chk("post_rst_vs_cycles", c_vs, VS_LINES * HT);
        chk("post_rst_en_cycles", c_en, 96);
        chk("post_rst_frame_done", c_fd, 1);
        chk("post_rst_underrun", underrun, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
